// File: rtl/inst_cache_sa_if.sv
// Fetch-side and memory-side handshake bundle for the set-associative
// instruction cache. The slave modport is the cache; the master modport is
// its environment (IF stage plus MemCtrl).
interface inst_cache_sa_if #(
  parameter int ADDR_W = 32
);
  logic              IF_inst_read_valid;
  logic [ADDR_W-1:0] IF_inst_addr;
  logic              IF_inst_valid;
  logic [31:0]       IF_inst;
  logic              MemCtrl_inst_read_valid;
  logic [ADDR_W-1:0] MemCtrl_inst_addr;
  logic              MemCtrl_inst_valid;
  logic [31:0]       MemCtrl_inst;

  modport slave (
    input  IF_inst_read_valid, IF_inst_addr, MemCtrl_inst_valid, MemCtrl_inst,
    output IF_inst_valid, IF_inst, MemCtrl_inst_read_valid, MemCtrl_inst_addr
  );

  modport master (
    output IF_inst_read_valid, IF_inst_addr, MemCtrl_inst_valid, MemCtrl_inst,
    input  IF_inst_valid, IF_inst, MemCtrl_inst_read_valid, MemCtrl_inst_addr
  );
endinterface

// File: rtl/inst_cache_sa.sv
// Set-associative instruction cache with multi-word lines, LRU replacement,
// a registered one-cycle hit path and a sequential word-by-word refill.
// A flush invalidates every line in one cycle; a flush caught mid-word
// drains the outstanding memory read before returning to idle.
module inst_cache_sa #(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic           flush,
  inst_cache_sa_if.slave bus
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  localparam int DIX_W = IDX_W + OFF_W;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_GAP, S_RESP, S_DRAIN
  } state_t;

  // Control state (reset) and registered outputs
  state_t                      state_q, state_d;
  logic [OFF_W-1:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic                        victim_q, victim_d;
  logic                        if_valid_q, if_valid_d;
  logic [31:0]                 if_inst_q, if_inst_d;
  logic                        mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
  logic [WAYS-1:0][SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]             lru_q, lru_d;

  // Storage arrays (no reset)
  logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
  logic [31:0]      data_mem [WAYS][SETS*LINE_WORDS];

  logic data_we, tag_we;

  // Request address fields
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [OFF_W-1:0] req_off;
  assign req_idx = bus.IF_inst_addr[OFF_W+2 +: IDX_W];
  assign req_tag = bus.IF_inst_addr[ADDR_W-1 -: TAG_W];
  assign req_off = bus.IF_inst_addr[2 +: OFF_W];

  // Latched miss address fields
  logic [IDX_W-1:0] m_idx;
  logic [TAG_W-1:0] m_tag;
  logic [OFF_W-1:0] m_off;
  assign m_idx = addr_q[OFF_W+2 +: IDX_W];
  assign m_tag = addr_q[ADDR_W-1 -: TAG_W];
  assign m_off = addr_q[2 +: OFF_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.IF_inst_addr[1:0], addr_q[1:0]};

  // LRU points at the way to evict next; with one way it stays 0
  function automatic logic lru_after(input logic used_way);
    return (WAYS == 2) ? ~used_way : 1'b0;
  endfunction

  logic hit, hit_way, victim;
  logic [31:0] hit_word, fill_word;

  // Tag compare across all ways of the requested set, and victim selection
  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = w[0];
      end
    end
    victim = lru_q[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx]) victim = w[0];
    end
  end

  assign hit_word  = data_mem[hit_way][{req_idx, req_off}];
  // The requested word is either arriving now (last word) or already written
  assign fill_word = (m_off == cnt_q) ? bus.MemCtrl_inst
                                      : data_mem[victim_q][{m_idx, m_off}];

  // Next-state and next-output computation for the lookup/refill FSM
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    victim_d   = victim_q;
    if_valid_d = 1'b0;
    if_inst_d  = '0;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    valid_d    = valid_q;
    lru_d      = lru_q;
    data_we    = 1'b0;
    tag_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.IF_inst_read_valid) begin
          if (hit) begin
            if_valid_d     = 1'b1;
            if_inst_d      = hit_word;
            lru_d[req_idx] = lru_after(hit_way);
            state_d        = S_RESP;
          end else begin
            addr_d     = bus.IF_inst_addr;
            cnt_d      = '0;
            victim_d   = victim;
            mem_req_d  = 1'b1;
            mem_addr_d = {bus.IF_inst_addr[ADDR_W-1:OFF_W+2], {OFF_W{1'b0}}, 2'b00};
            state_d    = S_REQ;
          end
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.MemCtrl_inst_valid) begin
          data_we    = 1'b1;
          mem_req_d  = 1'b0;
          mem_addr_d = '0;
          if (cnt_q != OFF_W'(LINE_WORDS - 1)) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_GAP;
          end else begin
            tag_we                   = 1'b1;
            valid_d[victim_q][m_idx] = 1'b1;
            lru_d[m_idx]             = lru_after(victim_q);
            if_valid_d               = 1'b1;
            if_inst_d                = fill_word;
            state_d                  = S_RESP;
          end
        end
      end
      S_GAP: begin
        mem_req_d  = 1'b1;
        mem_addr_d = {addr_q[ADDR_W-1:OFF_W+2], cnt_q, 2'b00};
        state_d    = S_REQ;
      end
      S_RESP: state_d = S_IDLE;
      S_DRAIN: begin
        if (bus.MemCtrl_inst_valid) begin
          mem_req_d  = 1'b0;
          mem_addr_d = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over any install or response computed above
    if (flush) begin
      valid_d    = '0;
      lru_d      = '0;
      if_valid_d = 1'b0;
      if_inst_d  = '0;
      case (state_q)
        S_WAIT: begin
          if (!bus.MemCtrl_inst_valid) state_d = S_DRAIN;
          else                         state_d = S_IDLE;
        end
        S_DRAIN: ;
        default: begin
          mem_req_d  = 1'b0;
          mem_addr_d = '0;
          state_d    = S_IDLE;
        end
      endcase
    end
  end

  // Control and output registers; rdy low freezes everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      victim_q   <= 1'b0;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= '0;
      lru_q      <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      victim_q   <= victim_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
      lru_q      <= lru_d;
    end
  end

  // Tag and data array writes during refill
  always_ff @(posedge clk) begin
    if (rdy && data_we) data_mem[victim_q][{m_idx, cnt_q}] <= bus.MemCtrl_inst;
    if (rdy && tag_we)  tag_mem[victim_q][m_idx]           <= m_tag;
  end

  // A flush arriving while the response is on the bus cancels it
  logic kill_resp;
  assign kill_resp = flush & rdy;

  assign bus.IF_inst_valid           = if_valid_q & ~kill_resp;
  assign bus.IF_inst                 = kill_resp ? 32'h0 : if_inst_q;
  assign bus.MemCtrl_inst_read_valid = mem_req_q;
  assign bus.MemCtrl_inst_addr       = mem_addr_q;

endmodule

// File: tb/tb_inst_cache_sa.sv
// Directed bench for inst_cache_sa: a 2-way instance (defaults) and a
// 1-way instance share one stimulus set, selected by 'sel'.
module tb_inst_cache_sa;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        sel = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_cache_sa_if #(.ADDR_W(32)) b0 ();
  inst_cache_sa_if #(.ADDR_W(32)) b1 ();

  assign b0.IF_inst_read_valid = if_req & ~sel;
  assign b0.IF_inst_addr       = if_addr;
  assign b0.MemCtrl_inst_valid = mem_valid & ~sel;
  assign b0.MemCtrl_inst       = mem_data;
  assign b1.IF_inst_read_valid = if_req & sel;
  assign b1.IF_inst_addr       = if_addr;
  assign b1.MemCtrl_inst_valid = mem_valid & sel;
  assign b1.MemCtrl_inst       = mem_data;

  inst_cache_sa #(.ADDR_W(32), .SETS(64), .WAYS(2), .LINE_WORDS(4)) u_two (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush & ~sel), .bus(b0.slave)
  );
  inst_cache_sa #(.ADDR_W(32), .SETS(64), .WAYS(1), .LINE_WORDS(4)) u_one (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush & sel), .bus(b1.slave)
  );

  logic        o_ifv, o_mreq;
  logic [31:0] o_inst, o_maddr;
  assign o_ifv   = sel ? b1.IF_inst_valid           : b0.IF_inst_valid;
  assign o_inst  = sel ? b1.IF_inst                 : b0.IF_inst;
  assign o_mreq  = sel ? b1.MemCtrl_inst_read_valid : b0.MemCtrl_inst_read_valid;
  assign o_maddr = sel ? b1.MemCtrl_inst_addr       : b0.MemCtrl_inst_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // At a negedge where the DUT shows a request: check it, answer next cycle
  task automatic serve_word(input logic [31:0] exp_addr, input logic [31:0] data);
    chk("mreq_on", {31'b0, o_mreq}, 32'h1);
    chk("maddr", o_maddr, exp_addr);
    @(negedge clk);
    chk("mreq_wait", {31'b0, o_mreq}, 32'h1);
    mem_valid = 1'b1;
    mem_data  = data;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_data  = '0;
  endtask

  // Serve words first_k..3 of the line holding addr, then check the response
  task automatic refill(input logic [31:0] addr, input logic [31:0] base, input int first_k);
    logic [31:0] line;
    line = addr & ~32'hF;
    for (int k = first_k; k < 4; k++) begin
      serve_word(line + 32'(4 * k), base + 32'(k));
      if (k < 3) begin
        chk("gap_mreq", {31'b0, o_mreq}, 32'h0);
        chk("gap_ifv", {31'b0, o_ifv}, 32'h0);
        @(negedge clk);
      end
    end
    chk("miss_ifv", {31'b0, o_ifv}, 32'h1);
    chk("miss_inst", o_inst, base + ((addr >> 2) & 32'h3));
    chk("miss_mreq", {31'b0, o_mreq}, 32'h0);
    if_req = 1'b0;
    @(negedge clk);
    chk("miss_ifv_off", {31'b0, o_ifv}, 32'h0);
    chk("miss_inst_off", o_inst, 32'h0);
  endtask

  task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] base);
    if_req  = 1'b1;
    if_addr = addr;
    @(negedge clk);
    refill(addr, base, 0);
  endtask

  task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] exp);
    if_req  = 1'b1;
    if_addr = addr;
    @(negedge clk);
    chk("hit_ifv", {31'b0, o_ifv}, 32'h1);
    chk("hit_inst", o_inst, exp);
    chk("hit_mreq", {31'b0, o_mreq}, 32'h0);
    if_req = 1'b0;
    @(negedge clk);
    chk("hit_ifv_off", {31'b0, o_ifv}, 32'h0);
    chk("hit_mreq_off", {31'b0, o_mreq}, 32'h0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ifv", {31'b0, o_ifv}, 32'h0);
    chk("rst_inst", o_inst, 32'h0);
    chk("rst_mreq", {31'b0, o_mreq}, 32'h0);
    chk("rst_maddr", o_maddr, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss then hit in the same line
    fetch_miss(32'h0000_0008, 32'hA0);
    fetch_hit(32'h0000_000C, 32'hA3);

    // Set conflict with LRU replacement (set stride 0x400)
    fetch_miss(32'h0000_0400, 32'hB0);
    fetch_hit(32'h0000_0000, 32'hA0);
    fetch_miss(32'h0000_0800, 32'hC0);
    fetch_hit(32'h0000_0004, 32'hA1);
    fetch_hit(32'h0000_0808, 32'hC2);
    fetch_miss(32'h0000_0404, 32'hB0);
    fetch_hit(32'h0000_040C, 32'hB3);

    // Flush while idle invalidates a hitting line
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle_ifv", {31'b0, o_ifv}, 32'h0);
    fetch_miss(32'h0000_0404, 32'hB0);

    // Flush while waiting for word 1: drain, no response, then full refill
    if_req  = 1'b1;
    if_addr = 32'h0000_0020;
    @(negedge clk);
    serve_word(32'h0000_0020, 32'hD0);
    chk("fw_gap", {31'b0, o_mreq}, 32'h0);
    @(negedge clk);
    chk("fw_req1", {31'b0, o_mreq}, 32'h1);
    chk("fw_addr1", o_maddr, 32'h0000_0024);
    @(negedge clk);
    flush  = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("drain_req", {31'b0, o_mreq}, 32'h1);
    chk("drain_addr", o_maddr, 32'h0000_0024);
    @(negedge clk);
    chk("drain_req2", {31'b0, o_mreq}, 32'h1);
    mem_valid = 1'b1;
    mem_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_valid = 1'b0;
    chk("drain_done_req", {31'b0, o_mreq}, 32'h0);
    chk("drain_no_resp", {31'b0, o_ifv}, 32'h0);
    @(negedge clk);
    chk("drain_idle_req", {31'b0, o_mreq}, 32'h0);
    chk("drain_idle_ifv", {31'b0, o_ifv}, 32'h0);
    fetch_miss(32'h0000_0020, 32'hD0);

    // rdy low for 5 cycles during GAP
    if_req  = 1'b1;
    if_addr = 32'h0000_0038;
    @(negedge clk);
    serve_word(32'h0000_0030, 32'hE0);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("frz_mreq", {31'b0, o_mreq}, 32'h0);
      chk("frz_maddr", o_maddr, 32'h0);
      chk("frz_ifv", {31'b0, o_ifv}, 32'h0);
      @(negedge clk);
    end
    rdy = 1'b1;
    chk("frz_still_gap", {31'b0, o_mreq}, 32'h0);
    @(negedge clk);
    refill(32'h0000_0038, 32'hE0, 1);

    // Asynchronous reset in WAIT clears outputs at once
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    @(negedge clk);
    serve_word(32'h0000_0040, 32'hF0);
    @(negedge clk);
    chk("rw_addr1", o_maddr, 32'h0000_0044);
    @(negedge clk);
    chk("rw_wait", {31'b0, o_mreq}, 32'h1);
    rst    = 1'b0;
    if_req = 1'b0;
    #1;
    chk("arst_mreq", {31'b0, o_mreq}, 32'h0);
    chk("arst_maddr", o_maddr, 32'h0);
    chk("arst_ifv", {31'b0, o_ifv}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fetch_miss(32'h0000_0040, 32'hF0);
    fetch_miss(32'h0000_0008, 32'hA0);

    // Direct-mapped instance: conflicting lines evict each other
    sel = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fetch_miss(32'h0000_0000, 32'hA0);
    fetch_miss(32'h0000_0400, 32'hB0);
    fetch_miss(32'h0000_0000, 32'hA0);
    fetch_miss(32'h0000_0404, 32'hB0);
    fetch_hit(32'h0000_0408, 32'hB2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_cache_sa.md
Name: inst_cache_sa

Overview:
- Parametrised set-associative instruction cache between the IF stage and MemCtrl; successor to the direct-mapped single-word instruction cache.
- Adds multi-word lines with a sequential word-by-word refill FSM, configurable ways with LRU replacement, a registered hit path, and a one-cycle full-cache flush for fence.i.
- Keeps the same IF-side and MemCtrl-side handshake signal names.

Parameters:
- ADDR_W, 32, address width.
- SETS, 64, number of sets; power of 2, at least 2.
- WAYS, 2, associativity; 1 or 2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  invalidate the entire cache (fence.i).
- IF_inst_read_valid  in  1  fetch request; held with a stable address until IF_inst_valid.
- IF_inst_addr  in  ADDR_W  fetch address; bits [1:0] ignored.
- IF_inst_valid  out  1  one-cycle response pulse.
- IF_inst  out  32  instruction; valid only with IF_inst_valid.
- MemCtrl_inst_read_valid  out  1  word read request.
- MemCtrl_inst_addr  out  ADDR_W  word address, 4-byte aligned.
- MemCtrl_inst_valid  in  1  one-cycle pulse: requested word returned.
- MemCtrl_inst  in  32  returned word.

Behaviour:
- Address split:
  - [1:0] ignored.
  - OFF = log2(LINE_WORDS) bits above [1:0].
  - IDX = log2(SETS) bits above OFF.
  - TAG = the remaining upper bits.
- Storage:
  - Valid bit per (set, way) held in flops.
  - Tag and data arrays need no reset.
  - One LRU bit per set; unused when WAYS=1.
- Reset (rst=0, asynchronous):
  - All valid bits 0, LRU 0, state IDLE, word counter 0.
  - IF_inst_valid=0, IF_inst=0, MemCtrl_inst_read_valid=0, MemCtrl_inst_addr=0.
  - Reset mid-refill abandons the refill; no line is written.
- rdy=0: no state, array or output changes. Incoming MemCtrl_inst_valid pulses are ignored, so MemCtrl must not complete while rdy=0.
- States: IDLE, REQ, WAIT, GAP, RESP, DRAIN.
- IDLE:
  - If IF_inst_read_valid=1, perform a tag lookup in all ways of IDX.
  - Hit: latch the word, set LRU to the other way, go to RESP. Hit latency is 1 cycle.
  - Miss: latch the request address, clear the word counter, choose the victim, go to REQ.
  - Victim choice: lowest-index invalid way; otherwise the way indicated by LRU.
- REQ:
  - MemCtrl_inst_read_valid=1.
  - MemCtrl_inst_addr = {TAG, IDX, counter, 2'b00}.
  - Words are fetched in order from 0, not critical-word-first.
  - Next state is WAIT.
- WAIT:
  - Request and address held until MemCtrl_inst_valid=1.
  - On that pulse, write the word into the victim way at the counter position and deassert MemCtrl_inst_read_valid on the next cycle.
  - If counter < LINE_WORDS-1: increment the counter and go to GAP.
  - If this was the last word: set the victim tag and valid bit, set LRU to the other way, latch the requested word, go to RESP.
  - Miss latency: the sum of the per-word MemCtrl latencies plus one idle cycle between words.
- GAP: MemCtrl_inst_read_valid=0 for exactly one cycle, then REQ.
- RESP:
  - IF_inst_valid=1 for exactly one cycle, with IF_inst driven.
  - No new lookup occurs this cycle.
  - Next state IDLE, so peak throughput is one instruction per 2 cycles.
- Outputs outside RESP: IF_inst_valid=0 and IF_inst=0.
- Outputs outside REQ and WAIT: MemCtrl_inst_read_valid=0 and MemCtrl_inst_addr=0.
- flush=1, all states:
  - All valid bits clear at the next edge; LRU cleared.
  - flush has priority over a simultaneous line install; the installed line ends up invalid.
  - IDLE: any lookup that cycle is cancelled and the cache stays in IDLE.
  - RESP: the response is suppressed (IF_inst_valid=0) and the cache goes to IDLE.
  - REQ or GAP: go to IDLE; no further requests are issued.
  - WAIT: go to DRAIN. DRAIN keeps the request asserted until MemCtrl_inst_valid, discards the word, then goes to IDLE with no response.
- IF changing its address during a refill is illegal.
- Line write-in and a same-set lookup never overlap, because lookups occur only in IDLE.

Test Plan:
- Cold miss, ADDR 0x0000_0008, defaults:
  - MemCtrl requests go to 0x0, 0x4, 0x8, 0xC, each followed by exactly one gap cycle.
  - Memory returns words 0xA0..0xA3.
  - IF_inst=0xA2 is pulsed once.
  - A following request to 0x0000_000C hits: IF_inst=0xA3 one cycle after the request, with no MemCtrl activity.
- Set conflict, defaults (set stride 0x400):
  - Fill 0x000, then 0x400, then hit 0x000.
  - Then miss 0x800: it evicts the 0x400 line (LRU).
  - Then 0x000 hits, and 0x400 misses and refills.
- WAYS=1:
  - 0x000 then 0x400 miss alternately, evicting each other.
  - Each access issues 4 MemCtrl requests.
- Flush:
  - Flush during WAIT of word 1: the cache waits for MemCtrl_inst_valid, discards the word, issues no response, returns to IDLE.
  - The re-request to the same address misses and refills all 4 words.
  - Flush while idle makes a previously hitting address miss.
- rdy and reset:
  - rdy=0 for 5 cycles during GAP: outputs frozen, GAP lasts 1 enabled cycle.
  - rst=0 asserted mid-WAIT clears outputs immediately, without waiting for a clock edge.
  - After reset the same address misses.
